// File: rtl/fetch_entry_fifo_pkg.sv
// Core configuration values and small helpers shared by the fetch entry FIFO.
package fetch_entry_fifo_pkg;

  // Core configuration: PC width, fetch-user enable and fetch-user width.
  localparam int unsigned CVA6ConfigXlen           = 64;
  localparam int unsigned CVA6ConfigFetchUserEn    = 0;
  localparam int unsigned CVA6ConfigFetchUserWidth = 64;

  // Default number of FIFO entries.
  localparam int unsigned FetchFifoDepth = 4;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fetch_entry_fifo_ptr_ctrl.sv
// Generic FIFO bookkeeping: read/write pointers, occupancy counter,
// full/empty flags and flush/reset handling.
module fifo_ptr_ctrl
  import fetch_entry_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = FetchFifoDepth
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_req_i,
  input  logic                       pop_req_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic                       push_o,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr_o,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  // Handshake flags depend only on registered state, so out-side ready
  // never reaches in_ready combinationally.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = push_req_i && !w_full  && !flush_i;
  assign w_pop   = pop_req_i  && !w_empty && !flush_i;

  // Next occupancy from the push/pop pair; simultaneous push+pop holds it.
  always_comb begin
    // NOTE: default first so every path assigns w_count_nxt and no latch is inferred.
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer and counter registers; reset and flush both return to empty.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments for state so every register samples pre-edge values.
    if (rst_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
    end
  end

  assign ready_o  = !w_full;
  assign valid_o  = !w_empty;
  assign push_o   = w_push;
  assign wr_ptr_o = r_wr_ptr;
  assign rd_ptr_o = r_rd_ptr;
  assign count_o  = r_count;

  // Occupancy must stay within 0..DEPTH.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_count <= CW'(DEPTH)));
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    (w_full |-> !w_push));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (w_empty |-> !w_pop));
  a_depth_legal: assert property (@(posedge clk_i)
    (DEPTH >= 2 && is_pow2(DEPTH)));

endmodule

// File: rtl/fetch_entry_fifo.sv
// Decoupling FIFO between instruction fetch and decode. Holds PC,
// instruction word, optional fetch-user bits and the fetch-exception flag.
module fetch_entry_fifo
  import fetch_entry_fifo_pkg::*;
#(
  parameter int unsigned XLEN             = CVA6ConfigXlen,
  parameter int unsigned FETCH_USER_EN    = CVA6ConfigFetchUserEn,
  parameter int unsigned FETCH_USER_WIDTH = CVA6ConfigFetchUserWidth,
  parameter int unsigned DEPTH            = FetchFifoDepth
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [XLEN-1:0]             in_pc_i,
  input  logic [31:0]                 in_instr_i,
  input  logic [FETCH_USER_WIDTH-1:0] in_user_i,
  input  logic                        in_ex_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [XLEN-1:0]             out_pc_o,
  output logic [31:0]                 out_instr_o,
  output logic [FETCH_USER_WIDTH-1:0] out_user_o,
  output logic                        out_ex_o,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Full entry as seen by decode.
  typedef struct packed {
    logic [XLEN-1:0]             pc;
    logic [31:0]                 instr;
    logic [FETCH_USER_WIDTH-1:0] user;
    logic                        ex;
  } fetch_entry_t;

  // Fields that are always stored; user bits live in their own array.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            ex;
  } fetch_base_t;

  fetch_base_t  r_mem [DEPTH];
  fetch_entry_t w_head;
  logic [AW-1:0] w_wr_ptr;
  logic [AW-1:0] w_rd_ptr;
  logic          w_push;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .push_req_i (in_valid_i),
    .pop_req_i  (out_ready_i),
    .ready_o    (in_ready_o),
    .valid_o    (out_valid_o),
    .push_o     (w_push),
    .wr_ptr_o   (w_wr_ptr),
    .rd_ptr_o   (w_rd_ptr),
    .count_o    (count_o)
  );

  // Entry storage written at the write pointer on an accepted push.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; stale contents are hidden behind out_valid_o.
    if (w_push) r_mem[w_wr_ptr] <= '{pc: in_pc_i, instr: in_instr_i, ex: in_ex_i};
  end

  // User bits are stored only when enabled; otherwise the output is tied off.
  if (FETCH_USER_EN != 0) begin : g_user
    logic [FETCH_USER_WIDTH-1:0] r_user [DEPTH];

    // User-bit storage written alongside the main entry.
    always_ff @(posedge clk_i) begin
      if (w_push) r_user[w_wr_ptr] <= in_user_i;
    end

    assign w_head.user = r_user[w_rd_ptr];
  end else begin : g_no_user
    logic w_unused_user;
    assign w_unused_user = ^in_user_i;
    assign w_head.user   = '0;
  end

  assign w_head.pc    = r_mem[w_rd_ptr].pc;
  assign w_head.instr = r_mem[w_rd_ptr].instr;
  assign w_head.ex    = r_mem[w_rd_ptr].ex;

  assign out_pc_o    = w_head.pc;
  assign out_instr_o = w_head.instr;
  assign out_user_o  = w_head.user;
  assign out_ex_o    = w_head.ex;

endmodule
